// File: rtl/cordic_sequencer_pkg.sv
// Shared constants, mode encodings and FSM state type for the CORDIC sequencer.
package cordic_sequencer_pkg;

  localparam int unsigned FIXED_WIDTH_DEF = 16;
  localparam int unsigned FRAC_BITS_DEF   = 13;
  localparam int unsigned ITERATIONS_DEF  = 9;

  localparam logic [1:0] CIRCULAR_MODE   = 2'b00;
  localparam logic [1:0] LINEAR_MODE     = 2'b01;
  localparam logic [1:0] HYPERBOLIC_MODE = 2'b10;

  // 1/K for the circular gain, Q0.15
  localparam int unsigned GAIN_INV   = 19898;
  localparam int unsigned GAIN_SHIFT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Only circular and linear coordinate systems are implemented
  function automatic logic mode_supported(input logic [1:0] m);
    return (m == CIRCULAR_MODE) || (m == LINEAR_MODE);
  endfunction

endpackage

// File: rtl/CORDIC_iteration.sv
// Combinational CORDIC micro-rotation: one shift-add step in circular or linear mode.
module CORDIC_iteration
  import cordic_sequencer_pkg::*;
#(
  parameter int unsigned FIXED_WIDTH = FIXED_WIDTH_DEF,
  parameter int unsigned SHIFT_W     = 4
) (
  input  logic signed [FIXED_WIDTH-1:0] x,
  input  logic signed [FIXED_WIDTH-1:0] y,
  input  logic signed [FIXED_WIDTH-1:0] z,
  input  logic signed [FIXED_WIDTH-1:0] delta_z,
  input  logic        [SHIFT_W-1:0]     shift,
  input  logic        [1:0]             mode,
  input  logic                          is_sigma_positive,
  output logic signed [FIXED_WIDTH-1:0] next_x,
  output logic signed [FIXED_WIDTH-1:0] next_y,
  output logic signed [FIXED_WIDTH-1:0] next_z
);

  logic signed [FIXED_WIDTH-1:0] x_sh;
  logic signed [FIXED_WIDTH-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  // Rotate by +/- the step angle; linear mode leaves x untouched
  always_comb begin
    next_x = x;
    next_y = y;
    next_z = z;
    if (is_sigma_positive) begin
      next_x = x - y_sh;
      next_y = y + x_sh;
      next_z = z - delta_z;
    end else begin
      next_x = x + y_sh;
      next_y = y - x_sh;
      next_z = z + delta_z;
    end
    if (mode == LINEAR_MODE) next_x = x;
  end

endmodule

// File: rtl/cordic_sequencer_atan_lut.sv
// Per-iteration z step: atan(2^-i) for circular, 2^-i for linear, in FRAC_BITS fixed point.
module cordic_atan_lut
  import cordic_sequencer_pkg::*;
#(
  parameter int unsigned FIXED_WIDTH = FIXED_WIDTH_DEF,
  parameter int unsigned FRAC_BITS   = FRAC_BITS_DEF,
  parameter int unsigned SHIFT_W     = 4
) (
  input  logic        [SHIFT_W-1:0]     shift,
  input  logic        [1:0]             mode,
  output logic signed [FIXED_WIDTH-1:0] delta_z_c
);

  logic [FIXED_WIDTH-1:0] pow2_step;

  // 2^-i scaled by 2^FRAC_BITS; vanishes once i passes FRAC_BITS
  always_comb begin
    pow2_step = '0;
    if (32'(shift) <= FRAC_BITS) pow2_step = FIXED_WIDTH'(1) << (FRAC_BITS - 32'(shift));
  end

  // Arctangent table is rounded for Q3.13; beyond i=8 atan(2^-i) ~ 2^-i
  always_comb begin
    delta_z_c = pow2_step;
    if (mode == CIRCULAR_MODE) begin
      case (shift)
        SHIFT_W'(0): delta_z_c = FIXED_WIDTH'(6434);
        SHIFT_W'(1): delta_z_c = FIXED_WIDTH'(3798);
        SHIFT_W'(2): delta_z_c = FIXED_WIDTH'(2007);
        SHIFT_W'(3): delta_z_c = FIXED_WIDTH'(1019);
        SHIFT_W'(4): delta_z_c = FIXED_WIDTH'(511);
        SHIFT_W'(5): delta_z_c = FIXED_WIDTH'(256);
        SHIFT_W'(6): delta_z_c = FIXED_WIDTH'(128);
        SHIFT_W'(7): delta_z_c = FIXED_WIDTH'(64);
        SHIFT_W'(8): delta_z_c = FIXED_WIDTH'(32);
        default:     delta_z_c = pow2_step;
      endcase
    end
  end

endmodule

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC controller: latches operands, steps CORDIC_iteration once per clock,
// reports done/busy/err. Optional circular gain compensation under CORDIC_GAIN_COMP_EN.
module cordic_sequencer
  import cordic_sequencer_pkg::*;
#(
  parameter int unsigned FIXED_WIDTH = FIXED_WIDTH_DEF,
  parameter int unsigned ITERATIONS  = ITERATIONS_DEF,
  parameter int unsigned FRAC_BITS   = FRAC_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic        [1:0]             mode,
  input  logic                          vectoring,
  input  logic signed [FIXED_WIDTH-1:0] x_in,
  input  logic signed [FIXED_WIDTH-1:0] y_in,
  input  logic signed [FIXED_WIDTH-1:0] z_in,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic signed [FIXED_WIDTH-1:0] x_out,
  output logic signed [FIXED_WIDTH-1:0] y_out,
  output logic signed [FIXED_WIDTH-1:0] z_out
);

  localparam int unsigned CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

  state_e                        state;
  logic [CNT_W-1:0]              count;
  logic [1:0]                    mode_q;
  logic                          vec_q;
  logic                          sigma_pos_c;
  logic signed [FIXED_WIDTH-1:0] delta_z_c;
  logic signed [FIXED_WIDTH-1:0] next_x;
  logic signed [FIXED_WIDTH-1:0] next_y;
  logic signed [FIXED_WIDTH-1:0] next_z;

  // Vectoring drives y toward zero, rotation drives z toward zero
  assign sigma_pos_c = vec_q ? y_out[FIXED_WIDTH-1] : ~z_out[FIXED_WIDTH-1];

  cordic_atan_lut #(
    .FIXED_WIDTH (FIXED_WIDTH),
    .FRAC_BITS   (FRAC_BITS),
    .SHIFT_W     (CNT_W)
  ) u_atan_lut (
    .shift     (count),
    .mode      (mode_q),
    .delta_z_c (delta_z_c)
  );

  CORDIC_iteration #(
    .FIXED_WIDTH (FIXED_WIDTH),
    .SHIFT_W     (CNT_W)
  ) u_iteration (
    .x                 (x_out),
    .y                 (y_out),
    .z                 (z_out),
    .delta_z           (delta_z_c),
    .shift             (count),
    .mode              (mode_q),
    .is_sigma_positive (sigma_pos_c),
    .next_x            (next_x),
    .next_y            (next_y),
    .next_z            (next_z)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [2*FIXED_WIDTH-1:0] GAIN_INV_W = (2*FIXED_WIDTH)'(GAIN_INV);

  logic signed [2*FIXED_WIDTH-1:0] x_prod;
  logic signed [2*FIXED_WIDTH-1:0] y_prod;
  logic signed [2*FIXED_WIDTH-1:0] x_shr;
  logic signed [2*FIXED_WIDTH-1:0] y_shr;

  // Full-width product before the Q0.15 renormalising shift
  assign x_prod = (2*FIXED_WIDTH)'(x_out) * GAIN_INV_W;
  assign y_prod = (2*FIXED_WIDTH)'(y_out) * GAIN_INV_W;
  assign x_shr  = x_prod >>> GAIN_SHIFT;
  assign y_shr  = y_prod >>> GAIN_SHIFT;
`endif

  // Control FSM and working registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      mode_q <= CIRCULAR_MODE;
      vec_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (mode_supported(mode)) begin
              x_out  <= x_in;
              y_out  <= y_in;
              z_out  <= z_in;
              mode_q <= mode;
              vec_q  <= vectoring;
              count  <= '0;
              busy   <= 1'b1;
              done   <= 1'b0;
              err    <= 1'b0;
              state  <= ST_RUN;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          x_out <= next_x;
          y_out <= next_y;
          z_out <= next_z;
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
`ifdef CORDIC_GAIN_COMP_EN
            if (mode_q == CIRCULAR_MODE) begin
              state <= ST_SCALE;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`else
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_SCALE: begin
          x_out <= x_shr[FIXED_WIDTH-1:0];
          y_out <= y_shr[FIXED_WIDTH-1:0];
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: scoreboard of bit-exact model results,
// plus tolerance checks against the ideal trigonometric/linear answers.
module tb_cordic_sequencer;

`ifdef CORDIC_GAIN_COMP_EN
  localparam bit GAIN = 1'b1;
`else
  localparam bit GAIN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic        [1:0]  mode;
  logic               vectoring;
  logic signed [15:0] x_in, y_in, z_in;
  logic               busy, done, err;
  logic signed [15:0] x_out, y_out, z_out;

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic               err;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   atan_tab [9] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32};

  always #5 clk = ~clk;

  cordic_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .vectoring (vectoring),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int exp_lat(input logic [1:0] m);
    return (m == 2'b00 && GAIN) ? 11 : 10;
  endfunction

  // Reference: nine shift-add micro-rotations with 16-bit wrap, then optional 1/K scaling
  function automatic exp_t model(input logic signed [15:0] x0, y0, z0,
                                 input logic [1:0] m, input logic v);
    exp_t r;
    logic signed [15:0] x, y, z, nx, ny, nz, dz;
    logic pos;
    int p;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < 9; i++) begin
      if (m == 2'b00) dz = 16'(atan_tab[i]);
      else            dz = 16'(8192 >> i);
      pos = v ? (y < 0) : (z >= 0);
      nx = pos ? x - (y >>> i) : x + (y >>> i);
      ny = pos ? y + (x >>> i) : y - (x >>> i);
      nz = pos ? z - dz : z + dz;
      if (m == 2'b01) nx = x;
      x = nx; y = ny; z = nz;
    end
    if (GAIN && m == 2'b00) begin
      p = int'(x) * 19898; x = 16'(p >>> 15);
      p = int'(y) * 19898; y = 16'(p >>> 15);
    end
    r.x = x; r.y = y; r.z = z; r.err = 1'b0;
    return r;
  endfunction

  // Drive one start pulse and push its expected result; returns just after the sampling edge
  task automatic launch(input int xi, input int yi, input int zi,
                        input logic [1:0] m, input logic v);
    exp_t e;
    @(negedge clk);
    x_in = 16'(xi); y_in = 16'(yi); z_in = 16'(zi);
    mode = m; vectoring = v; start = 1'b1;
    if (m == 2'b00 || m == 2'b01) begin
      e = model(16'(xi), 16'(yi), 16'(zi), m, v);
    end else begin
      e = last_exp;
      e.err = 1'b1;
    end
    last_exp = e;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; lat counts edges starting with the start-sampling edge
  task automatic await_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; vectoring = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    last_exp = '{x: 16'sd0, y: 16'sd0, z: 16'sd0, err: 1'b0};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/err=%b want 000", {busy, done, err});
    end
    checks++;
    if ({x_out, y_out, z_out} !== 48'h0) begin
      errors++; $display("FAIL reset_outputs: got %0d %0d %0d want 0 0 0", x_out, y_out, z_out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_circular_rotation();
    exp_t e; int lat; int tgt, tol;
    launch(8192, 0, 6434, 2'b00, 1'b0);
    await_done(1, lat);
    e = sb.pop_front();
    checks++;
    if (x_out !== e.x || y_out !== e.y || z_out !== e.z || err !== e.err) begin
      errors++; $display("FAIL circ_rot_exact: got %0d %0d %0d err=%b want %0d %0d %0d err=%b",
                         x_out, y_out, z_out, err, e.x, e.y, e.z, e.err);
    end
    checks++;
    if (lat != exp_lat(2'b00)) begin
      errors++; $display("FAIL circ_rot_latency: got %0d want %0d", lat, exp_lat(2'b00));
    end
    tgt = GAIN ? 5793 : 9540;
    tol = GAIN ? 32 : 48;
    checks++;
    if (iabs(int'(x_out) - tgt) > tol || iabs(int'(y_out) - tgt) > tol) begin
      errors++; $display("FAIL circ_rot_xy: got x=%0d y=%0d want %0d +/-%0d", x_out, y_out, tgt, tol);
    end
    checks++;
    if (iabs(int'(z_out)) > 32) begin
      errors++; $display("FAIL circ_rot_z: got %0d want 0 +/-32", z_out);
    end
  endtask

  task automatic test_circular_vectoring();
    exp_t e; int lat;
    launch(8192, 8192, 0, 2'b00, 1'b1);
    await_done(1, lat);
    e = sb.pop_front();
    checks++;
    if (x_out !== e.x || y_out !== e.y || z_out !== e.z || err !== e.err) begin
      errors++; $display("FAIL circ_vec_exact: got %0d %0d %0d err=%b want %0d %0d %0d err=%b",
                         x_out, y_out, z_out, err, e.x, e.y, e.z, e.err);
    end
    checks++;
    if (iabs(int'(z_out) - 6434) > 32) begin
      errors++; $display("FAIL circ_vec_z: got %0d want 6434 +/-32", z_out);
    end
    // y residual is bounded by the last micro-rotation, x>>8 (about 75 here)
    checks++;
    if (iabs(int'(y_out)) > 80) begin
      errors++; $display("FAIL circ_vec_y: got %0d want 0 +/-80", y_out);
    end
  endtask

  task automatic test_linear_rotation();
    exp_t e; int lat;
    launch(4096, 0, 4096, 2'b01, 1'b0);
    await_done(1, lat);
    e = sb.pop_front();
    checks++;
    if (x_out !== e.x || y_out !== e.y || z_out !== e.z || err !== e.err) begin
      errors++; $display("FAIL lin_rot_exact: got %0d %0d %0d err=%b want %0d %0d %0d err=%b",
                         x_out, y_out, z_out, err, e.x, e.y, e.z, e.err);
    end
    checks++;
    if (x_out !== 16'sd4096) begin
      errors++; $display("FAIL lin_rot_x: got %0d want 4096", x_out);
    end
    checks++;
    if (iabs(int'(y_out) - 2048) > 16) begin
      errors++; $display("FAIL lin_rot_y: got %0d want 2048 +/-16", y_out);
    end
    checks++;
    if (lat != 10) begin
      errors++; $display("FAIL lin_rot_latency: got %0d want 10", lat);
    end
  endtask

  task automatic test_bad_mode();
    exp_t e; int lat;
    for (int k = 0; k < 2; k++) begin
      launch(1111, 2222, 3333, (k == 0) ? 2'b10 : 2'b11, 1'b0);
      await_done(1, lat);
      e = sb.pop_front();
      checks++;
      if ({busy, done, err} !== 3'b011 || lat != 1) begin
        errors++; $display("FAIL bad_mode_flags[%0d]: got busy/done/err=%b lat=%0d want 011 lat=1",
                           k, {busy, done, err}, lat);
      end
      checks++;
      if (x_out !== e.x || y_out !== e.y || z_out !== e.z) begin
        errors++; $display("FAIL bad_mode_hold[%0d]: got %0d %0d %0d want %0d %0d %0d",
                           k, x_out, y_out, z_out, e.x, e.y, e.z);
      end
    end
    launch(4096, 0, 4096, 2'b01, 1'b0);
    checks++;
    if ({busy, done, err} !== 3'b100) begin
      errors++; $display("FAIL bad_mode_clear: got busy/done/err=%b want 100", {busy, done, err});
    end
    await_done(1, lat);
    e = sb.pop_front();
    checks++;
    if (x_out !== e.x || y_out !== e.y || z_out !== e.z || err !== e.err) begin
      errors++; $display("FAIL bad_mode_recover: got %0d %0d %0d err=%b want %0d %0d %0d err=%b",
                         x_out, y_out, z_out, err, e.x, e.y, e.z, e.err);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e; int lat;
    launch(8192, 0, 6434, 2'b00, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err} !== 3'b000 || {x_out, y_out, z_out} !== 48'h0) begin
      errors++; $display("FAIL mid_run_reset: got flags=%b out=%0d %0d %0d want 000 0 0 0",
                         {busy, done, err}, x_out, y_out, z_out);
    end
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    last_exp = '{x: 16'sd0, y: 16'sd0, z: 16'sd0, err: 1'b0};
    launch(8192, 8192, 0, 2'b00, 1'b1);
    await_done(1, lat);
    e = sb.pop_front();
    checks++;
    if (x_out !== e.x || y_out !== e.y || z_out !== e.z || err !== e.err || lat != exp_lat(2'b00)) begin
      errors++; $display("FAIL after_reset_run: got %0d %0d %0d err=%b lat=%0d want %0d %0d %0d err=%b lat=%0d",
                         x_out, y_out, z_out, err, lat, e.x, e.y, e.z, e.err, exp_lat(2'b00));
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e; int lat;
    launch(8192, 0, 6434, 2'b00, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    x_in = 16'sd100; y_in = -16'sd500; z_in = 16'sd1234; mode = 2'b01; vectoring = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL busy_start_flags: got busy/done=%b want 10", {busy, done});
    end
    await_done(5, lat);
    e = sb.pop_front();
    checks++;
    if (x_out !== e.x || y_out !== e.y || z_out !== e.z || err !== e.err || lat != exp_lat(2'b00)) begin
      errors++; $display("FAIL busy_start_result: got %0d %0d %0d err=%b lat=%0d want %0d %0d %0d err=%b lat=%0d",
                         x_out, y_out, z_out, err, lat, e.x, e.y, e.z, e.err, exp_lat(2'b00));
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; int xi, yi, zi; logic [1:0] m; logic v;
    for (int k = 0; k < 6; k++) begin
      m = 2'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      if (v) begin
        xi = int'($urandom_range(2048, 8192));
        yi = int'($urandom_range(0, 2 * xi)) - xi;
        zi = int'($urandom_range(0, 4000)) - 2000;
      end else begin
        xi = int'($urandom_range(0, 16384)) - 8192;
        yi = int'($urandom_range(0, 16384)) - 8192;
        zi = int'($urandom_range(0, 24000)) - 12000;
      end
      launch(xi, yi, zi, m, v);
      await_done(1, lat);
      e = sb.pop_front();
      checks++;
      if (x_out !== e.x || y_out !== e.y || z_out !== e.z || err !== e.err) begin
        errors++; $display("FAIL b2b_exact[%0d]: got %0d %0d %0d err=%b want %0d %0d %0d err=%b",
                           k, x_out, y_out, z_out, err, e.x, e.y, e.z, e.err);
      end
      checks++;
      if (lat != exp_lat(m)) begin
        errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, lat, exp_lat(m));
      end
    end
  endtask

  initial begin
    test_reset();
    test_circular_rotation();
    test_circular_vectoring();
    test_linear_rotation();
    test_bad_mode();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
